// File: rtl/ysyx_22040127_ifu_pkg.sv
// Shared definitions for the ysyx_22040127 instruction fetch unit:
// FSM state encodings, the default reset PC and the canonical NOP word.
package ysyx_22040127_ifu_pkg;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_e;

  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  // Redirect targets must land on a 4-byte boundary.
  function automatic logic [63:0] ifu_align4(input logic [63:0] pc);
    return pc & ~64'h0000_0000_0000_0003;
  endfunction

endpackage

// File: rtl/ysyx_22040127_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handshake
// and execute redirect. master = fetch unit side, slave = memory/decode/execute side.
interface ysyx_22040127_ifu_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, instruction, inst_pc,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, instruction, inst_pc,
    output inst_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit: owns the PC, issues one outstanding 32-bit fetch at a
// time, buffers the returned word for decode and honours execute redirects.
module ysyx_22040127_ifu
  import ysyx_22040127_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22040127_ifu_if.master   bus,
  output logic [63:0]           fetch_cnt
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_buf_q, pc_buf_d;
  logic            kill_q, kill_d;
  logic [31:0]     inst_buf_q, inst_buf_d;
  logic [63:0]     fetch_cnt_q, fetch_cnt_d;

  logic [XLEN-1:0] redirect_tgt_s;
  logic            handshake_s;

  assign redirect_tgt_s = XLEN'(ifu_align4(64'(bus.redirect_pc)));
  assign handshake_s    = (state_q == IFU_HOLD) && bus.inst_ready;

  // Next-state logic; a redirect overrides the normal flow in every state.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pc_buf_d    = pc_buf_q;
    kill_d      = kill_q;
    inst_buf_d  = inst_buf_q;
    fetch_cnt_d = handshake_s ? (fetch_cnt_q + 64'd1) : fetch_cnt_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_tgt_s;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    case (state_q)
      IFU_REQ: begin
        if (bus.imem_req_ready) begin
          state_d = IFU_WAIT;
          kill_d  = bus.redirect_valid;
        end else begin
          state_d = IFU_REQ;
        end
      end
      IFU_WAIT: begin
        if (bus.imem_resp_valid) begin
          kill_d = 1'b0;
          if (!kill_q && !bus.redirect_valid) begin
            inst_buf_d = bus.imem_resp_data;
            pc_buf_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + XLEN'(3'd4);
            state_d    = IFU_HOLD;
          end else begin
            state_d = IFU_REQ;
          end
        end else if (bus.redirect_valid) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end
      IFU_HOLD: begin
        if (bus.redirect_valid || bus.inst_ready) begin
          state_d = IFU_REQ;
        end else begin
          state_d = IFU_HOLD;
        end
      end
      default: begin
        state_d = IFU_REQ;
        kill_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IFU_REQ;
      fetch_pc_q  <= RESET_PC;
      pc_buf_q    <= {XLEN{1'b0}};
      kill_q      <= 1'b0;
      inst_buf_q  <= 32'h0000_0000;
      fetch_cnt_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pc_buf_q    <= pc_buf_d;
      kill_q      <= kill_d;
      inst_buf_q  <= inst_buf_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // The request is masked while rst is held so nothing is issued during reset.
  assign bus.imem_req_valid = (state_q == IFU_REQ) && !rst;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = (state_q == IFU_HOLD);
  assign bus.instruction    = inst_buf_q;
  assign bus.inst_pc        = pc_buf_q;
  assign fetch_cnt          = fetch_cnt_q;

endmodule
